pwr_seq_fsm: RTL and testbench
==============================

Name: pwr_seq_fsm

Overview:
- Board power-sequencing controller that sits directly upstream of the rail-enable pins and the BMC PCIe reset pin.
- Consumes the 1 ms tick from the shared ms timer chain, plus the VCORE_EN request and the four PWRGD inputs.
- Drives P1V8_EN, P3V3_EN, P1V1_EN and R_BMC_PCIE_RST_N.
- Replaces the chain of free-running per-rail n-ms timers with one FSM that adds PWRGD timeouts, fault latching and reverse-order power-down.

Parameters:
- DLY_STEP_MS, 6, dwell in ms after each PWRGD before the next step; also the dwell of each power-down step.
- DLY_LAST_MS, 10, dwell in ms after P1V1 PWRGD before PCIe reset release.
- PWRGD_TO_MS, 100, maximum wait in ms for a rail's PWRGD after its enable asserts.
- CNT_W, 11, ms counter width; must hold max(DLY_STEP_MS, DLY_LAST_MS, PWRGD_TO_MS).

Ports:
- sys_clk  in  1  system clock (50 MHz).
- sys_rst_n  in  1  asynchronous, active-low reset.
- ms_pulse  in  1  one-cycle 1 ms tick, synchronous to sys_clk.
- vcore_en  in  1  sequence request (VCORE_EN).
- vcore_pwrgd  in  1  VCORE power good.
- p1v8_pwrgd  in  1  P1V8 power good.
- p3v3_pwrgd  in  1  P3V3 power good.
- p1v1_pwrgd  in  1  P1V1 power good.
- fault_clr  in  1  one-cycle fault acknowledge from BMC GPIO/I2C.
- p1v8_en  out  1  P1V8 enable.
- p3v3_en  out  1  P3V3 enable.
- p1v1_en  out  1  P1V1 enable.
- pcie_rst_n  out  1  BMC PCIe reset, active low.
- fault  out  1  sticky fault flag.
- fault_code  out  3  latched cause.
- state_dbg  out  4  current state encoding, for the LED/debug mux.

Behaviour:
- Reset: state=IDLE; all enables=0; pcie_rst_n=0; fault=0; fault_code=0; counter=0.
- Asynchronous assert, synchronous release. The PWRGD/vcore_en inputs are already synchronous/deglitched upstream.
- All outputs are flops loaded from the next-state decode, so each output changes on the same edge the state changes. No combinational output paths.
- ms counter:
  - Cleared on every state entry.
  - Increments on each cycle with ms_pulse=1.
  - A dwell of N ends on the edge after the N-th pulse seen in the state, so the real delay lies in (N-1, N] ms.
- States and transitions:
  - IDLE: vcore_en & vcore_pwrgd -> DLY_VC.
  - DLY_VC: after DLY_STEP_MS -> W18, p1v8_en=1.
  - W18: p1v8_pwrgd -> D18. Counter reaching PWRGD_TO_MS -> FAULT, code 2.
  - D18: after DLY_STEP_MS -> W33, p3v3_en=1.
  - W33: p3v3_pwrgd -> D33. Timeout -> FAULT, code 3.
  - D33: after DLY_STEP_MS -> W11, p1v1_en=1.
  - W11: p1v1_pwrgd -> D11. Timeout -> FAULT, code 4.
  - D11: after DLY_LAST_MS -> RUN, pcie_rst_n=1.
  - RUN: holds until vcore_en=0 or a fault occurs.
  - PD11: pcie_rst_n=0 and p1v1_en=0 on entry; after DLY_STEP_MS -> PD33.
  - PD33: p3v3_en=0 on entry; after DLY_STEP_MS -> PD18.
  - PD18: p1v8_en=0 on entry; after DLY_STEP_MS -> IDLE.
  - FAULT: all enables=0, pcie_rst_n=0 on entry; fault=1; code latched. Exits to IDLE only when fault_clr=1 and vcore_en=0 in the same cycle; fault and fault_code clear on that edge.
- Fault checks, active in every state from DLY_VC through RUN:
  - vcore_pwrgd=0 -> code 1.
  - Any previously confirmed rail PWRGD (one whose wait state has passed) going 0 -> code 5.
- Priority per cycle: fault > vcore_en deassert > normal progress.
- Simultaneous faults: lowest code wins.
- vcore_en drop in any state DLY_VC..RUN -> PD11. Rails already off simply dwell, so shutdown is always reverse order.
- Power-down states ignore PWRGD faults and vcore_en re-assertion. Re-sequencing starts only from IDLE.
- fault_clr outside FAULT is ignored.
- Reset mid-operation: all outputs drop asynchronously to their reset values.
- Counter saturates at all-ones and never wraps.

Decomposition:
- Shared package pwr_seq_pkg holds:
  - state encoding localparams: IDLE=0, DLY_VC=1, W18=2, D18=3, W33=4, D33=5, W11=6, D11=7, RUN=8, PD11=9, PD33=10, PD18=11, FAULT=12.
  - fault code constants: NONE=0, VCORE_LOST=1, TO_1V8=2, TO_3V3=3, TO_1V1=4, RAIL_LOST=5.
- One natural sub-module, ms_dwell_cnt: clear, tick and saturating count with a compare-to-N done output. It is instanced once and shared across states.

Test Plan:
- Nominal: vcore_en=vcore_pwrgd=1 and every PWRGD returns 1 ms after its enable -> p1v8_en at ~6 ms, p3v3_en ~6 ms after P1V8 PWRGD, p1v1_en likewise, pcie_rst_n=1 at 10 ms after P1V1 PWRGD; state_dbg=8.
- Timeout: hold p3v3_pwrgd=0 -> at the 100th ms_pulse in W33, fault=1, fault_code=3, all enables=0, pcie_rst_n=0.
- Power-down: vcore_en 1->0 in RUN -> pcie_rst_n=0 and p1v1_en=0 next edge; p3v3_en=0 6 ms later; p1v8_en=0 6 ms after that; IDLE 6 ms after that.
- Rail loss and priority: in RUN, drop p1v8_pwrgd and vcore_en in the same cycle -> FAULT, code 5 (not PD11). fault_clr with vcore_en=1 -> stays in FAULT. fault_clr with vcore_en=0 -> IDLE, code 0.
- Abort mid-sequence: vcore_en=0 during W33 -> PD11 -> PD33 -> PD18 -> IDLE, with p1v8_en=0 only at PD18 entry.
- Async reset in RUN: sys_rst_n=0 mid-cycle -> all enables, pcie_rst_n and fault go 0 before the next sys_clk edge.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the board power sequencer: state encoding (visible on state_dbg),
// latched fault causes, and a small range helper. The sequencing states are numbered in
// order, so every rail-enable window is a contiguous range of states.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StDlyVc = 4'd1,
    StW18   = 4'd2,
    StD18   = 4'd3,
    StW33   = 4'd4,
    StD33   = 4'd5,
    StW11   = 4'd6,
    StD11   = 4'd7,
    StRun   = 4'd8,
    StPd11  = 4'd9,
    StPd33  = 4'd10,
    StPd18  = 4'd11,
    StFault = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    FcNone      = 3'd0,
    FcVcoreLost = 3'd1,
    FcTo1v8     = 3'd2,
    FcTo3v3     = 3'd3,
    FcTo1v1     = 3'd4,
    FcRailLost  = 3'd5
  } fault_code_e;

  // True when lo <= s <= hi in state-encoding order.
  function automatic logic in_range(state_e s, state_e lo, state_e hi);
    return (s >= lo) && (s <= hi);
  endfunction

endpackage

// File: rtl/pwr_seq_fsm_if.sv
// Signal bundle between the power sequencer and the board.
//   master : sequencer side (takes tick/request/PWRGD/clear, drives enables and status)
//   slave  : board side (drives tick/request/PWRGD/clear, observes enables and status)
interface pwr_seq_fsm_if;
  logic       ms_pulse;
  logic       vcore_en;
  logic       vcore_pwrgd;
  logic       p1v8_pwrgd;
  logic       p3v3_pwrgd;
  logic       p1v1_pwrgd;
  logic       fault_clr;
  logic       p1v8_en;
  logic       p3v3_en;
  logic       p1v1_en;
  logic       pcie_rst_n;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] state_dbg;

  modport master (
    input  ms_pulse, vcore_en, vcore_pwrgd, p1v8_pwrgd, p3v3_pwrgd, p1v1_pwrgd, fault_clr,
    output p1v8_en, p3v3_en, p1v1_en, pcie_rst_n, fault, fault_code, state_dbg
  );

  modport slave (
    output ms_pulse, vcore_en, vcore_pwrgd, p1v8_pwrgd, p3v3_pwrgd, p1v1_pwrgd, fault_clr,
    input  p1v8_en, p3v3_en, p1v1_en, pcie_rst_n, fault, fault_code, state_dbg
  );
endinterface

// File: rtl/ms_dwell_cnt.sv
// Saturating millisecond dwell counter shared by all sequencer states.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : zero the count (state entry); wins over tick_i
//   tick_i        : 1 ms pulse
//   limit_i       : dwell length N in ms
//   done_o        : high in the cycle whose tick brings the count to N (or beyond)
module ms_dwell_cnt #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  // One bit wider so the compare is correct even when the count is saturated.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign done_o  = tick_i && (cnt_inc >= {1'b0, limit_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwr_seq_fsm.sv
// Board power-sequencing controller: VCORE -> P1V8 -> P3V3 -> P1V1 -> PCIe reset release,
// with PWRGD timeouts, sticky fault latching and reverse-order power-down.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (master)       : ms tick, VCORE_EN request, PWRGD inputs, fault_clr in;
//                        rail enables, pcie_rst_n, fault, fault_code, state_dbg out.
// Every output is a flop loaded from the next-state decode.
module pwr_seq_fsm
  import pwr_seq_pkg::*;
#(
  parameter int unsigned DLY_STEP_MS = 6,
  parameter int unsigned DLY_LAST_MS = 10,
  parameter int unsigned PWRGD_TO_MS = 100,
  parameter int unsigned CNT_W       = 11
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  pwr_seq_fsm_if.master bus
);

  state_e           state_q, state_d;
  fault_code_e      cause;
  logic [2:0]       fault_code_q, fault_code_d;
  logic             p1v8_en_q, p1v8_en_d;
  logic             p3v3_en_q, p3v3_en_d;
  logic             p1v1_en_q, p1v1_en_d;
  logic             pcie_rst_n_q, pcie_rst_n_d;
  logic             fault_q, fault_d;
  logic             seq_active, rail_lost, done;
  logic [CNT_W-1:0] limit;

  // PWRGD wait states time out; the last dwell is longer; everything else is one step.
  always_comb begin
    limit = CNT_W'(DLY_STEP_MS);
    if (state_q == StW18 || state_q == StW33 || state_q == StW11) begin
      limit = CNT_W'(PWRGD_TO_MS);
    end else if (state_q == StD11) begin
      limit = CNT_W'(DLY_LAST_MS);
    end
  end

  ms_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (state_d != state_q),
    .tick_i  (bus.ms_pulse),
    .limit_i (limit),
    .done_o  (done)
  );

  always_comb begin
    state_d    = state_q;
    cause      = FcNone;
    seq_active = in_range(state_q, StDlyVc, StRun);
    // A rail counts as confirmed once its wait state is behind us.
    rail_lost  = (in_range(state_q, StD18, StRun) && !bus.p1v8_pwrgd) ||
                 (in_range(state_q, StD33, StRun) && !bus.p3v3_pwrgd) ||
                 (in_range(state_q, StD11, StRun) && !bus.p1v1_pwrgd);

    // Lowest code wins when several causes coincide.
    if (seq_active) begin
      if (!bus.vcore_pwrgd) begin
        cause = FcVcoreLost;
      end else if (state_q == StW18 && done) begin
        cause = FcTo1v8;
      end else if (state_q == StW33 && done) begin
        cause = FcTo3v3;
      end else if (state_q == StW11 && done) begin
        cause = FcTo1v1;
      end else if (rail_lost) begin
        cause = FcRailLost;
      end
    end

    unique case (state_q)
      StIdle:  if (bus.vcore_en && bus.vcore_pwrgd) state_d = StDlyVc;
      StDlyVc: if (done) state_d = StW18;
      StW18:   if (bus.p1v8_pwrgd) state_d = StD18;
      StD18:   if (done) state_d = StW33;
      StW33:   if (bus.p3v3_pwrgd) state_d = StD33;
      StD33:   if (done) state_d = StW11;
      StW11:   if (bus.p1v1_pwrgd) state_d = StD11;
      StD11:   if (done) state_d = StRun;
      StRun:   state_d = StRun;
      StPd11:  if (done) state_d = StPd33;
      StPd33:  if (done) state_d = StPd18;
      StPd18:  if (done) state_d = StIdle;
      StFault: if (bus.fault_clr && !bus.vcore_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Fault beats request drop, which beats normal progress.
    if (seq_active) begin
      if (cause != FcNone) begin
        state_d = StFault;
      end else if (!bus.vcore_en) begin
        state_d = StPd11;
      end
    end

    // Enable windows span W.. through the matching power-down step, giving reverse order.
    p1v8_en_d    = in_range(state_d, StW18, StPd33);
    p3v3_en_d    = in_range(state_d, StW33, StPd11);
    p1v1_en_d    = in_range(state_d, StW11, StRun);
    pcie_rst_n_d = (state_d == StRun);
    fault_d      = (state_d == StFault);

    if (state_d != StFault) begin
      fault_code_d = FcNone;
    end else if (state_q != StFault) begin
      fault_code_d = cause;
    end else begin
      fault_code_d = fault_code_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      fault_code_q <= 3'd0;
      p1v8_en_q    <= 1'b0;
      p3v3_en_q    <= 1'b0;
      p1v1_en_q    <= 1'b0;
      pcie_rst_n_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      p1v8_en_q    <= p1v8_en_d;
      p3v3_en_q    <= p3v3_en_d;
      p1v1_en_q    <= p1v1_en_d;
      pcie_rst_n_q <= pcie_rst_n_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.p1v8_en    = p1v8_en_q;
  assign bus.p3v3_en    = p3v3_en_q;
  assign bus.p1v1_en    = p1v1_en_q;
  assign bus.pcie_rst_n = pcie_rst_n_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_pwr_seq_fsm.sv
// Bench for pwr_seq_fsm. A board model returns each rail's PWRGD a random number of ms
// after its enable; ms ticks arrive with random gaps. Expected event times are derived
// from the sequencing rules as pulse-count arithmetic.
module tb_pwr_seq_fsm;

  localparam int OutP1v8  = 0;
  localparam int OutP3v3  = 1;
  localparam int OutP1v1  = 2;
  localparam int OutPcie  = 3;
  localparam int OutFault = 4;
  localparam int OutState = 5;
  localparam int OutCode  = 6;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  pwr_seq_fsm_if bus ();

  pwr_seq_fsm #(
    .DLY_STEP_MS (6),
    .DLY_LAST_MS (10),
    .PWRGD_TO_MS (100),
    .CNT_W       (11)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass   = 0;
  int n_checks = 0;
  int pulse_cnt = 0;
  int gap = 2;
  int dly[3];
  int rise_k[3];
  bit armed[3];
  bit pg[3];
  bit stuck[3];
  bit kill[3];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  function automatic int get_out(input int idx);
    case (idx)
      OutP1v8:  return int'(bus.p1v8_en);
      OutP3v3:  return int'(bus.p3v3_en);
      OutP1v1:  return int'(bus.p1v1_en);
      OutPcie:  return int'(bus.pcie_rst_n);
      OutFault: return int'(bus.fault);
      OutState: return int'(bus.state_dbg);
      OutCode:  return int'(bus.fault_code);
      default:  return -1;
    endcase
  endfunction

  // One clock: count the tick the DUT sees, then update board and tick at the falling edge.
  task automatic step();
    bit en[3];
    @(posedge sys_clk);
    if (bus.ms_pulse) pulse_cnt++;
    @(negedge sys_clk);
    en[0] = bus.p1v8_en;
    en[1] = bus.p3v3_en;
    en[2] = bus.p1v1_en;
    for (int i = 0; i < 3; i++) begin
      if (!en[i]) begin
        pg[i] = 1'b0;
        armed[i] = 1'b0;
      end else begin
        if (!armed[i]) begin
          armed[i] = 1'b1;
          rise_k[i] = pulse_cnt;
        end
        if (!stuck[i] && (pulse_cnt - rise_k[i] >= dly[i])) pg[i] = 1'b1;
      end
    end
    bus.p1v8_pwrgd = pg[0] & ~kill[0];
    bus.p3v3_pwrgd = pg[1] & ~kill[1];
    bus.p1v1_pwrgd = pg[2] & ~kill[2];
    // Never two ticks back to back.
    if (gap == 0) begin
      bus.ms_pulse = 1'b1;
      gap = $urandom_range(1, 3);
    end else begin
      bus.ms_pulse = 1'b0;
      gap--;
    end
  endtask

  task automatic wait_out(input string tag, input int idx, input int val, input int budget,
                          output int k);
    int n = 0;
    while (get_out(idx) != val && n < budget) begin
      step();
      n++;
    end
    if (get_out(idx) != val) begin
      check_eq({tag, "_timeout"}, get_out(idx), val);
      k = -1000;
    end else begin
      k = pulse_cnt;
    end
  endtask

  task automatic set_rails(input bit stuck_3v3);
    for (int i = 0; i < 3; i++) begin
      dly[i] = $urandom_range(1, 5);
      stuck[i] = 1'b0;
      kill[i] = 1'b0;
    end
    stuck[1] = stuck_3v3;
  endtask

  // IDLE -> W33; returns the pulse count at which p3v3_en rose.
  task automatic seq_start(output int k2);
    int k0, k1;
    bus.vcore_pwrgd = 1'b1;
    bus.vcore_en = 1'b1;
    step();
    check_eq("req_state", get_out(OutState), 1);
    check_eq("req_p1v8_off", get_out(OutP1v8), 0);
    k0 = pulse_cnt;
    wait_out("p1v8_on", OutP1v8, 1, 200, k1);
    check_eq("p1v8_on_ms", k1 - k0, 6);
    wait_out("p3v3_on", OutP3v3, 1, 200, k2);
    check_eq("p3v3_on_ms", k2 - k1, dly[0] + 6);
  endtask

  task automatic seq_finish(input int k2);
    int k3, k4;
    wait_out("p1v1_on", OutP1v1, 1, 200, k3);
    check_eq("p1v1_on_ms", k3 - k2, dly[1] + 6);
    check_eq("pcie_held", get_out(OutPcie), 0);
    wait_out("pcie_rel", OutPcie, 1, 300, k4);
    check_eq("pcie_rel_ms", k4 - k3, dly[2] + 10);
    check_eq("run_state", get_out(OutState), 8);
    check_eq("run_fault", get_out(OutFault), 0);
  endtask

  task automatic power_down(input string tag);
    int k0, k;
    bus.vcore_en = 1'b0;
    step();
    check_eq({tag, "_pd_state"}, get_out(OutState), 9);
    check_eq({tag, "_pd_pcie"}, get_out(OutPcie), 0);
    check_eq({tag, "_pd_p1v1"}, get_out(OutP1v1), 0);
    check_eq({tag, "_pd_p3v3_on"}, get_out(OutP3v3), 1);
    k0 = pulse_cnt;
    wait_out({tag, "_p3v3_off"}, OutP3v3, 0, 200, k);
    check_eq({tag, "_p3v3_off_ms"}, k - k0, 6);
    check_eq({tag, "_p1v8_still_on"}, get_out(OutP1v8), 1);
    wait_out({tag, "_p1v8_off"}, OutP1v8, 0, 200, k);
    check_eq({tag, "_p1v8_off_ms"}, k - k0, 12);
    wait_out({tag, "_idle"}, OutState, 0, 200, k);
    check_eq({tag, "_idle_ms"}, k - k0, 18);
  endtask

  task automatic check_fault(input string tag, input int code);
    check_eq({tag, "_state"}, get_out(OutState), 12);
    check_eq({tag, "_fault"}, get_out(OutFault), 1);
    check_eq({tag, "_code"}, get_out(OutCode), code);
    check_eq({tag, "_rails"},
             get_out(OutP1v8) + get_out(OutP3v3) + get_out(OutP1v1) + get_out(OutPcie), 0);
  endtask

  task automatic clear_fault(input string tag);
    bus.vcore_en = 1'b0;
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    check_eq({tag, "_clr_state"}, get_out(OutState), 0);
    check_eq({tag, "_clr_fault"}, get_out(OutFault), 0);
    check_eq({tag, "_clr_code"}, get_out(OutCode), 0);
  endtask

  initial begin
    int k2, kf;
    sys_rst_n = 1'b0;
    bus.ms_pulse = 1'b0;
    bus.vcore_en = 1'b0;
    bus.vcore_pwrgd = 1'b0;
    bus.p1v8_pwrgd = 1'b0;
    bus.p3v3_pwrgd = 1'b0;
    bus.p1v1_pwrgd = 1'b0;
    bus.fault_clr = 1'b0;
    set_rails(1'b0);
    repeat (3) step();
    check_eq("rst_state", get_out(OutState), 0);
    check_eq("rst_pcie", get_out(OutPcie), 0);
    check_eq("rst_fault", get_out(OutFault) + get_out(OutCode), 0);
    check_eq("rst_rails", get_out(OutP1v8) + get_out(OutP3v3) + get_out(OutP1v1), 0);
    sys_rst_n = 1'b1;
    step();
    check_eq("idle_no_req", get_out(OutState), 0);

    // Nominal bring-up and reverse power-down with random PWRGD delays.
    for (int it = 0; it < 3; it++) begin
      set_rails(1'b0);
      seq_start(k2);
      seq_finish(k2);
      power_down("nom");
    end

    // P3V3 never good: fault on the 100th tick in W33.
    set_rails(1'b1);
    seq_start(k2);
    wait_out("to_fault", OutFault, 1, 1000, kf);
    check_eq("to_fault_ms", kf - k2, 100);
    check_fault("to", 3);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    check_eq("clr_en_hi_state", get_out(OutState), 12);
    check_eq("clr_en_hi_code", get_out(OutCode), 3);
    clear_fault("to");

    // Rail loss together with request drop: fault wins.
    set_rails(1'b0);
    seq_start(k2);
    seq_finish(k2);
    kill[0] = 1'b1;
    bus.p1v8_pwrgd = 1'b0;
    bus.vcore_en = 1'b0;
    step();
    check_fault("rail", 5);
    clear_fault("rail");

    // VCORE loss together with P1V1 loss: lowest code wins.
    set_rails(1'b0);
    seq_start(k2);
    seq_finish(k2);
    kill[2] = 1'b1;
    bus.p1v1_pwrgd = 1'b0;
    bus.vcore_pwrgd = 1'b0;
    step();
    check_fault("vcore", 1);
    bus.vcore_pwrgd = 1'b1;
    clear_fault("vcore");

    // Abort while waiting for P3V3.
    set_rails(1'b1);
    seq_start(k2);
    repeat ($urandom_range(1, 20)) step();
    power_down("abort");

    // Async reset in RUN drops everything before the next edge.
    set_rails(1'b0);
    seq_start(k2);
    seq_finish(k2);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_eq("arst_rails", get_out(OutP1v8) + get_out(OutP3v3) + get_out(OutP1v1), 0);
    check_eq("arst_pcie", get_out(OutPcie), 0);
    check_eq("arst_state", get_out(OutState), 0);
    check_eq("arst_fault", get_out(OutFault), 0);
    bus.vcore_en = 1'b0;
    step();
    sys_rst_n = 1'b1;
    step();
    check_eq("post_arst_idle", get_out(OutState), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
